// File: rtl/ysyx_23060061_lsu.sv
// Load/store unit: registers one core memory request, issues it on a valid/ready
// data-memory bus, aligns store lanes / extracts load lanes, and reports errors.
module ysyx_23060061_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [1:0]            MemRW,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  lsu_done,
    output logic [31:0]           lsu_rdata,
    output logic                  lsu_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [31:0]           mem_req_wdata,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_wen;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wmask;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_bad;
    logic        w_expire;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_mask;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign w_accept   = lsu_valid && (r_state == S_IDLE) && (MemRW == 2'b10 || MemRW == 2'b01);
    assign w_illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
    assign w_bad      = w_illegal || w_misalign;
    // Saturating compare so an expiry lost to a handshake still fires in RESP.
    assign w_expire   = (r_cnt >= CW'(TIMEOUT - 1));

    always_comb begin
        w_st_data = wdata;
        w_st_mask = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_st_data = {4{wdata[7:0]}};
                w_st_mask = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_st_data = {2{wdata[15:0]}};
                w_st_mask = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign w_byte = mem_rsp_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = mem_rsp_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        lsu_ready     = 1'b0;
        lsu_done      = 1'b0;
        lsu_err       = 1'b0;
        lsu_rdata     = 32'd0;
        mem_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                lsu_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = w_bad ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_next = S_RESP;
                end else if (w_expire) begin
                    w_state_next = S_DONE;
                end
            end
            S_RESP: begin
                if (mem_rsp_valid || w_expire) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                lsu_done     = 1'b1;
                lsu_err      = r_err;
                lsu_rdata    = r_rdata;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wen    <= 1'b0;
            r_funct3 <= 3'd0;
            r_off    <= 2'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_wmask  <= 4'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wen    <= (MemRW == 2'b01);
                        r_funct3 <= funct3;
                        r_off    <= addr[1:0];
                        r_addr   <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        r_wdata  <= w_st_data;
                        r_wmask  <= (MemRW == 2'b01) ? w_st_mask : 4'd0;
                        r_rdata  <= 32'd0;
                        r_err    <= w_bad;
                        r_cnt    <= '0;
                    end
                end
                S_REQ: begin
                    if (r_cnt != CW'(TIMEOUT)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (!mem_req_ready && w_expire) begin
                        r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (r_cnt != CW'(TIMEOUT)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        r_rdata <= r_wen ? 32'd0 : w_ld_data;
                    end else if (w_expire) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_wen   = r_wen;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wmask = r_wmask;

endmodule

// File: doc/ysyx_23060061_lsu.md
# ysyx_23060061_lsu

Load/store unit: the responder for the decoder's `MemRW` request (00 idle, 10 read, 01 write) and `funct3` width code. It registers one memory request from the execute stage and issues it on a valid/ready data-memory bus. For stores it aligns write data and builds the byte mask; for loads it extracts, sign-extends or zero-extends the returned word. It stalls the core until completion, and reports misalignment and bus timeout as errors.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte-address width.
- `TIMEOUT`, 255: maximum cycles spent waiting in REQ or RESP before an error completion; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `lsu_valid`  in  1  core presents a request this cycle.
- `lsu_ready`  out  1  high only in IDLE; the request is accepted when `lsu_valid & lsu_ready` and `MemRW` is 10 or 01.
- `MemRW`  in  2  10 = load, 01 = store, 00/11 = no operation (ignored, never accepted).
- `funct3`  in  3  000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu; other codes are illegal and complete with error.
- `addr`  in  ADDR_WIDTH  byte address.
- `wdata`  in  32  store source (rs2).
- `lsu_done`  out  1  one-cycle completion pulse.
- `lsu_rdata`  out  32  load result; valid while `lsu_done`; 0 for stores and errors.
- `lsu_err`  out  1  qualifies `lsu_done`: misaligned, illegal funct3, or timeout.
- `mem_req_valid`  out  1  bus request.
- `mem_req_ready`  in  1  bus accepts the request.
- `mem_req_wen`  out  1  1 = write.
- `mem_req_addr`  out  ADDR_WIDTH  word-aligned address `{addr[ADDR_WIDTH-1:2], 2'b00}`.
- `mem_req_wdata`  out  32  lane-aligned store data.
- `mem_req_wmask`  out  4  byte enables; 0000 for reads.
- `mem_rsp_valid`  in  1  response (read data or write acknowledge).
- `mem_rsp_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, RESP, DONE. Reset puts the unit in IDLE with every output 0 except `lsu_ready` = 1.
- IDLE: on accept, register `MemRW`, `funct3`, `addr`, and `wdata`, then check:
  - Misaligned (h/hu with `addr[0]` = 1, w with `addr[1:0]` ≠ 0) or illegal `funct3`: go to DONE with error and issue no bus transaction.
  - Otherwise go to REQ.
- REQ: hold `mem_req_valid` = 1 with stable fields until `mem_req_ready`, then go to RESP.
- RESP: wait for `mem_rsp_valid`; capture the extracted data, then go to DONE.
- DONE: assert `lsu_done` for exactly one cycle, then go to IDLE.
- The timeout counter clears on entry to REQ and counts every cycle in REQ or RESP. When the counter reaches `TIMEOUT`, go to DONE with `lsu_err` = 1 and drop `mem_req_valid`.
- Store lanes:
  - sb: byte replicated into all four lanes; mask `4'b0001 << addr[1:0]`.
  - sh: halfword duplicated into both halves; mask 0011 if `addr[1]` = 0, else 1100.
  - sw: data unchanged; mask 1111.
- Load extraction: byte lane `addr[1:0]` or halfword lane `addr[1]`.
  - b/h: sign-extend to 32 bits.
  - bu/hu: zero-extend to 32 bits.
  - w: whole word.
- `mem_rsp_valid` outside RESP is ignored; this covers stale responses after a reset or timeout.

## Timing
- Minimum aligned-access latency is 3 cycles from the accept edge (edge 0):
  - REQ in cycle 1; if `mem_req_ready` is high, the handshake happens at edge 1.
  - `mem_rsp_valid` sampled at edge 2.
  - `lsu_done` is high in cycle 3.
- Each bus stall cycle adds one cycle of latency.
- Error completions (misaligned or illegal `funct3`): `lsu_done` and `lsu_err` are high in cycle 1.
- `lsu_ready` is 0 from cycle 1 through the DONE cycle inclusive. A new request can be accepted in the cycle after DONE at the earliest.
- `mem_req_*` outputs come from registers: no combinational path from core inputs to bus outputs.
- `rst_n` low at any edge, mid-transaction or not, forces IDLE at that edge. `mem_req_valid` and `lsu_done` are 0 in the next cycle, and the counter clears.
- If `mem_req_ready` and the timeout expiry occur on the same edge, the handshake wins and the unit goes to RESP with the counter continuing.
- If `mem_rsp_valid` and the timeout expiry occur on the same edge, the response wins and no error is raised.

## Test plan
- Store sb, `addr` = 0x80000003, `wdata` = 0x000000A5, bus always ready → `mem_req_addr` = 0x80000000, `wdata` = 0xA5A5A5A5, `wmask` = 1000, `wen` = 1; `lsu_done` in cycle 3 with `lsu_rdata` = 0.
- Load lb and lbu, `addr` = 0x80000002, `mem_rsp_rdata` = 0x12F03456 → lb returns 0xFFFFFFF0, lbu returns 0x000000F0.
- Load lh, `addr` = 0x80000001 → no `mem_req_valid` ever asserted; `lsu_done` = `lsu_err` = 1 in cycle 1.
- Load lw with `mem_req_ready` low for 4 cycles, then response 0xDEADBEEF 2 cycles after the handshake → request fields stable while stalled; `lsu_done` in cycle 8 with `lsu_rdata` = 0xDEADBEEF.
- `TIMEOUT` = 4, `mem_rsp_valid` never asserted → `lsu_err` = 1 after 4 cycles in REQ/RESP. A late `mem_rsp_valid` arriving in IDLE is ignored.
- Reset mid-RESP, then `lsu_valid` with `MemRW` = 11 → IDLE after the reset edge with `lsu_ready` = 1; the 11 request is not accepted, and no bus activity or `lsu_done` follows.
